// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-requester memory bus
//               arbiter: grant-state encoding and requester identifiers.
// Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter state: idle, or granted to requester 0 / requester 1.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  // Requester identifiers as carried on the round-robin pointer.
  localparam logic c_req_m0 = 1'b0;
  localparam logic c_req_m1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_rr2
// Description : Two-way round-robin pick. A lone requester always wins; on a
//               tie the requester that was not granted last wins.
// Ports       : i_req0, i_req1  request lines
//               i_last_gnt      id of the requester granted most recently
//               o_gnt_id        id of the winning requester
//               o_gnt_any       at least one request is pending
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_gnt_id,
  output logic o_gnt_any
);

  always_comb begin
    o_gnt_any = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt_id = ~i_last_gnt;
    end else if (i_req1) begin
      o_gnt_id = c_req_m1;
    end else begin
      o_gnt_id = c_req_m0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one PicoRV32-style memory port between two requesters.
//               Round-robin grant held for a whole burst (valid held high);
//               optional beat cap releases the bus to a waiting requester.
//               No buffering: address/data/strobes are muxed from the granted
//               requester, ready/rdata are routed back to it only.
// Parameters  : N         address/data width
//               MAX_HOLD  max mem_ready beats per grant while the other
//                         requester waits; 0 = unlimited
// Ports       : clk, resetn (async, active-low)
//               m0_*/m1_*  requester side (valid/addr/wstrb/wdata in,
//                          ready/rdata out)
//               mem_*      memory side (valid/addr/wstrb/wdata out,
//                          ready/rdata in)
//               gnt_cnt0, gnt_cnt1, wait_cnt  statistics outputs, present only
//                          when macro ARB_STATS_EN is defined
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         m0_valid,
  input  logic [N-1:0] m0_addr,
  input  logic [3:0]   m0_wstrb,
  input  logic [N-1:0] m0_wdata,
  output logic         m0_ready,
  output logic [N-1:0] m0_rdata,
  input  logic         m1_valid,
  input  logic [N-1:0] m1_addr,
  input  logic [3:0]   m1_wstrb,
  input  logic [N-1:0] m1_wdata,
  output logic         m1_ready,
  output logic [N-1:0] m1_rdata,
`ifdef ARB_STATS_EN
  output logic [31:0]  gnt_cnt0,
  output logic [31:0]  gnt_cnt1,
  output logic [31:0]  wait_cnt,
`endif
  output logic         mem_valid,
  output logic [N-1:0] mem_addr,
  output logic [3:0]   mem_wstrb,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata
);

  // Beat counter must hold 0..MAX_HOLD; at least one bit when the cap is off.
  localparam int                c_cnt_w     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic              c_hold_en   = (MAX_HOLD != 0);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic               r_last_gnt;
  logic [c_cnt_w-1:0] r_beat_cnt;
  logic               w_gnt_id;
  logic               w_gnt_any;
  logic               w_cur_valid;
  logic               w_oth_valid;
  logic               w_cap_hit;
  logic               w_grant_now;

  mem_arb_rr2 u_rr2 (
    .i_req0     (m0_valid),
    .i_req1     (m1_valid),
    .i_last_gnt (r_last_gnt),
    .o_gnt_id   (w_gnt_id),
    .o_gnt_any  (w_gnt_any)
  );

  // Valid of the current owner and of the other requester.
  always_comb begin
    w_cur_valid = (r_state == ST_GNT1) ? m1_valid : m0_valid;
    w_oth_valid = (r_state == ST_GNT1) ? m0_valid : m1_valid;
  end

  // Cap reached on this beat with someone waiting: give the bus up so the
  // round-robin pointer hands it to the other requester next.
  assign w_cap_hit   = c_hold_en && mem_ready && (r_beat_cnt == c_hold_last) && w_oth_valid;
  assign w_grant_now = (r_state == ST_IDLE) && w_gnt_any;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) begin
          w_next_state = (w_gnt_id == c_req_m1) ? ST_GNT1 : ST_GNT0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        // Owner dropping valid ends the burst, even for a single cycle.
        if (!w_cur_valid || w_cap_hit) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= c_req_m1;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_now) begin
        r_last_gnt <= w_gnt_id;
        r_beat_cnt <= '0;
      end else if ((r_state != ST_IDLE) && mem_ready && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
      end
    end
  end

  // Output mux: everything is zero while idle, so a reset mid-burst drops
  // the memory request in the same cycle.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wstrb = 4'h0;
    mem_wdata = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    case (r_state)
      ST_GNT0: begin
        mem_valid = m0_valid;
        mem_addr  = m0_addr;
        mem_wstrb = m0_wstrb;
        mem_wdata = m0_wdata;
        m0_ready  = mem_ready;
        m0_rdata  = mem_rdata;
      end
      ST_GNT1: begin
        mem_valid = m1_valid;
        mem_addr  = m1_addr;
        mem_wstrb = m1_wstrb;
        mem_wdata = m1_wdata;
        m1_ready  = mem_ready;
        m1_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  logic w_waiting;

  // Some requester has valid high but does not own the bus this cycle.
  always_comb begin
    case (r_state)
      ST_GNT0: w_waiting = m1_valid;
      ST_GNT1: w_waiting = m0_valid;
      default: w_waiting = m0_valid | m1_valid;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      wait_cnt <= '0;
    end else begin
      if (w_grant_now && (w_gnt_id == c_req_m0)) gnt_cnt0 <= gnt_cnt0 + 32'd1;
      if (w_grant_now && (w_gnt_id == c_req_m1)) gnt_cnt1 <= gnt_cnt1 + 32'd1;
      if (w_waiting) wait_cnt <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter (N=32,
//               MAX_HOLD=8): single read, round-robin ties, plain burst,
//               beat-cap rotation, ready while idle, async reset mid-burst.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
`ifdef ARB_STATS_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, wait_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int exp_st  = 0;  // state the DUT should be in during the current cycle

  always #5 clk = ~clk;

  mem_bus_arbiter #(.N(32), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0_valid  (m0_valid),
    .m0_addr   (m0_addr),
    .m0_wstrb  (m0_wstrb),
    .m0_wdata  (m0_wdata),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_addr   (m1_addr),
    .m1_wstrb  (m1_wstrb),
    .m1_wdata  (m1_wdata),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
`ifdef ARB_STATS_EN
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1),
    .wait_cnt  (wait_cnt),
`endif
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

`ifdef ARB_STATS_EN
  // Reference wait counter: a cycle counts when a valid requester is not the
  // one the directed sequence expects to own the bus.
  int mdl_wait = 0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mdl_wait <= 0;
    else if ((m0_valid && exp_st != 1) || (m1_valid && exp_st != 2)) mdl_wait <= mdl_wait + 1;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_valid = 0; m0_addr = 0; m0_wstrb = 0; m0_wdata = 0;
    m1_valid = 0; m1_addr = 0; m1_wstrb = 0; m1_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    clear_inputs();
    exp_st = 0;
    tick();
    tick();
    resetn = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state
    resetn = 0;
    clear_inputs();
    tick();
    smp();
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'd0);
    chk("rst_last_gnt", {31'd0, dut.r_last_gnt}, 32'd1);
    do_reset();

    // ---------------- single read by m0, one-cycle grant latency
    m0_valid = 1; m0_addr = 32'h100;
    smp();
    chk("t1_latency_idle", {31'd0, mem_valid}, 32'd0);
    tick(); smp();
    chk("t1_mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    mem_ready = 1; mem_rdata = 32'hCAFE; #1;
    chk("t1_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'hCAFE);
    chk("t1_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("t1_m1_rdata", m1_rdata, 32'd0);
    tick(); mem_ready = 0; m0_valid = 0;
    tick(); smp();
    chk("t1_release", {31'd0, mem_valid}, 32'd0);
    // mem_ready while idle must not reach either requester
    mem_ready = 1; #1;
    chk("idle_rdy_m0", {31'd0, m0_ready}, 32'd0);
    chk("idle_rdy_m1", {31'd0, m1_ready}, 32'd0);
    mem_ready = 0;

    // ---------------- tie after reset: m0, then m1, then m0 again
    do_reset();
    m0_valid = 1; m0_addr = 32'h300;
    m1_valid = 1; m1_addr = 32'h400; m1_wstrb = 4'hF; m1_wdata = 32'hDEADBEEF;
    exp_st = 0;
    tick(); exp_st = 1; smp();
    chk("tie1_addr", mem_addr, 32'h300);
    mem_ready = 1; #1;
    chk("tie1_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("tie1_m1_ready", {31'd0, m1_ready}, 32'd0);
    tick(); mem_ready = 0; m0_valid = 0;
    tick(); exp_st = 0; smp();
    chk("tie1_idle", {31'd0, mem_valid}, 32'd0);
    tick(); exp_st = 2; smp();
    chk("tie2_addr", mem_addr, 32'h400);
    chk("tie2_wstrb", {28'd0, mem_wstrb}, 32'hF);
    chk("tie2_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1; #1;
    chk("tie2_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("tie2_m0_ready", {31'd0, m0_ready}, 32'd0);
    tick(); mem_ready = 0; m1_valid = 0;
    tick(); exp_st = 0;
    m0_valid = 1; m1_valid = 1;
    tick(); exp_st = 1; smp();
    chk("tie3_addr", mem_addr, 32'h300);
    m0_valid = 0; m1_valid = 0;
    tick();
    tick(); exp_st = 0;
`ifdef ARB_STATS_EN
    chk("stat_gnt0", gnt_cnt0, 32'd2);
    chk("stat_gnt1", gnt_cnt1, 32'd1);
    chk("stat_wait", wait_cnt, 32'(mdl_wait));
`endif

    // ---------------- 4-beat burst, m1 idle: no gap in mem_valid
    do_reset();
    m0_valid = 1; m0_addr = 32'h200;
    tick();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("b4_valid%0d", i), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("b4_addr%0d", i), mem_addr, 32'h200 + 32'(4 * i));
      mem_ready = 1; mem_rdata = 32'(i);
      tick(); mem_ready = 0;
      if (i < 3) m0_addr = 32'h200 + 32'(4 * (i + 1));
      else m0_valid = 0;
    end
    tick(); smp();
    chk("b4_end", {31'd0, mem_valid}, 32'd0);

    // ---------------- 12-beat burst with m1 waiting: cap after 8 beats
    do_reset();
    m0_valid = 1; m0_addr = 32'h500;
    m1_valid = 1; m1_addr = 32'h600; m1_wstrb = 4'h0;
    tick();
    for (int i = 0; i < 8; i++) begin
      smp();
      chk($sformatf("cap_addr%0d", i), mem_addr, 32'h500 + 32'(4 * i));
      mem_ready = 1;
      tick(); mem_ready = 0;
      m0_addr = 32'h500 + 32'(4 * (i + 1));
    end
    smp();
    chk("cap_idle", {31'd0, mem_valid}, 32'd0);
    tick(); smp();
    chk("cap_m1_addr", mem_addr, 32'h600);
    mem_ready = 1; #1;
    chk("cap_m1_ready", {31'd0, m1_ready}, 32'd1);
    tick(); mem_ready = 0; m1_valid = 0;
    tick();
    tick(); smp();
    chk("cap_resume_valid", {31'd0, mem_valid}, 32'd1);
    chk("cap_resume_addr", mem_addr, 32'h520);
    for (int i = 8; i < 12; i++) begin
      smp();
      chk($sformatf("cap_tail%0d", i), mem_addr, 32'h500 + 32'(4 * i));
      mem_ready = 1;
      tick(); mem_ready = 0;
      if (i < 11) m0_addr = 32'h500 + 32'(4 * (i + 1));
      else m0_valid = 0;
    end
    tick();

    // ---------------- async reset during GNT1 beat 2
    do_reset();
    m1_valid = 1; m1_addr = 32'h700; m1_wstrb = 4'h3; m1_wdata = 32'h1234;
    tick();
    tick(); smp();
    chk("ar_beat1", mem_addr, 32'h700);
    mem_ready = 1;
    tick(); mem_ready = 0; m1_addr = 32'h704;
    smp();
    chk("ar_beat2_addr", mem_addr, 32'h704);
    mem_ready = 1; #1;
    resetn = 0; #1;
    chk("ar_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("ar_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("ar_mem_addr", mem_addr, 32'd0);
    chk("ar_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("ar_mem_wdata", mem_wdata, 32'd0);
    chk("ar_state", 32'(dut.r_state), 32'd0);
    chk("ar_last_gnt", {31'd0, dut.r_last_gnt}, 32'd1);
    clear_inputs();
    tick();
    resetn = 1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
